ex_stage_unit: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. It consumes the registered outputs of the ID/EX pipeline latch, performs the ALU operation, selects the destination register and computes the branch target. Results are registered into the EX/MEM boundary. An iterative shift-add multiplier inside the block raises a stall toward upstream stages while it is busy.

---
 rtl/ex_stage_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ex_stage_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_unit.sv
// ---------------------------------------------------------------------------
// ex_stage_unit
//
// Execute stage of a 5-stage MIPS pipeline. It takes the registered ID/EX
// latch contents, performs the ALU operation, selects the destination
// register, computes the branch target and registers everything into the
// EX/MEM boundary. MUL runs on an iterative shift-add multiplier that holds
// the upstream stages with ex_stall while it works.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   pc_next_in            PC+4 from ID/EX (W bits)
//   r_data1_in/2_in       rs / rt register values
//   sign_ext_in           sign-extended immediate, [5:0] is the funct field
//   inst_20_16_in         rt index
//   inst_15_11_in         rd index
//   wb_*_in, m_*_in       control carried through to EX/MEM
//   ex_RegDst_in          1: destination is rd, 0: destination is rt
//   ex_ALUOp_in           0: ADD, 1: decode funct
//   ex_ALUSrc_in          1: operand B is the immediate
//   ex_flush              squash the instruction currently in EX
//   ex_stall              combinational hold request toward ID/EX
//   pc_branch_out         registered branch target
//   alu_result_out        registered ALU result
//   zero_out              registered (ALU result == 0)
//   r_data2_out           registered store data
//   write_reg_out         registered destination register
//   wb_*_out, m_*_out     registered control (all 0 for a bubble)
//   fsm_state_o           debug view of the multiplier FSM (0 IDLE, 1 BUSY, 2 DONE)
//
// Stall handshake: while ex_stall is high the upstream stage must keep the
// ID/EX contents unchanged and the EX/MEM boundary receives a bubble on every
// edge. When ex_stall drops, the edge at the end of that cycle consumes the
// instruction presented on the inputs.
// ---------------------------------------------------------------------------
module ex_stage_unit #(
   parameter int B = 32,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] pc_next_in,
   input  logic [B-1:0] r_data1_in,
   input  logic [B-1:0] r_data2_in,
   input  logic [B-1:0] sign_ext_in,
   input  logic [W-1:0] inst_20_16_in,
   input  logic [W-1:0] inst_15_11_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   input  logic         ex_RegDst_in,
   input  logic         ex_ALUOp_in,
   input  logic         ex_ALUSrc_in,
   input  logic         ex_flush,
   output logic         ex_stall,
   output logic [W-1:0] pc_branch_out,
   output logic [B-1:0] alu_result_out,
   output logic         zero_out,
   output logic [B-1:0] r_data2_out,
   output logic [W-1:0] write_reg_out,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         m_Branch_out,
   output logic         m_MemRead_out,
   output logic         m_MemWrite_out,
   output logic [1:0]   fsm_state_o
);

   localparam int CW = $clog2(B);

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A;
   localparam logic [5:0] F_MUL = 6'h18;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [B-1:0]  mcand_q, mcand_d;
   logic [B-1:0]  mplier_q, mplier_d;
   logic [B-1:0]  acc_q, acc_d;

   logic [B-1:0]  alu_result_q, alu_result_d;
   logic          zero_q, zero_d;
   logic [B-1:0]  r_data2_q, r_data2_d;
   logic [W-1:0]  write_reg_q, write_reg_d;
   logic [W-1:0]  pc_branch_q, pc_branch_d;
   logic          reg_write_q, reg_write_d;
   logic          mem_to_reg_q, mem_to_reg_d;
   logic          branch_q, branch_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;

   logic [5:0]    funct;
   logic [B-1:0]  op_a;
   logic [B-1:0]  op_b;
   logic          mul_dec;
   logic [B-1:0]  alu_res;
   logic [B-1:0]  br_sum;
   logic          mul_load;
   logic          mul_step;
   logic          capture;

   // ---------------- operand selection and decode ----------------
   assign funct   = sign_ext_in[5:0];
   assign op_a    = r_data1_in;
   assign op_b    = ex_ALUSrc_in ? sign_ext_in : r_data2_in;
   // Branch forces SUB, so a branch with a MUL-like immediate never stalls.
   assign mul_dec = !m_Branch_in && ex_ALUOp_in && (funct == F_MUL);

   // The MUL entry returns the accumulator; it is only consumed in DONE.
   always_comb begin
      alu_res = '0;
      if (m_Branch_in) begin
         alu_res = op_a - op_b;
      end else if (!ex_ALUOp_in) begin
         alu_res = op_a + op_b;
      end else begin
         case (funct)
            F_ADD:   alu_res = op_a + op_b;
            F_SUB:   alu_res = op_a - op_b;
            F_AND:   alu_res = op_a & op_b;
            F_OR:    alu_res = op_a | op_b;
            F_NOR:   alu_res = ~(op_a | op_b);
            F_SLT:   alu_res = {{(B-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F_MUL:   alu_res = acc_q;
            default: alu_res = '0;
         endcase
      end
   end

   // Target is formed at full width, then truncated to the latch PC width.
   assign br_sum = B'(pc_next_in) + (sign_ext_in << 2);

   // ---------------- multiplier FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- multiplier FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (ex_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (mul_dec) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CW'(B-1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- multiplier FSM: outputs ----------------
   // Stall is gated by rst_n so it reads low while reset is asserted.
   always_comb begin
      ex_stall = 1'b0;
      mul_load = 1'b0;
      mul_step = 1'b0;
      capture  = 1'b0;
      if (rst_n && !ex_flush) begin
         case (state_q)
            S_IDLE: begin
               if (mul_dec) begin
                  ex_stall = 1'b1;
                  mul_load = 1'b1;
               end else begin
                  capture = 1'b1;
               end
            end
            S_BUSY: begin
               ex_stall = 1'b1;
               mul_step = 1'b1;
            end
            S_DONE:  capture = 1'b1;
            default: ;
         endcase
      end
   end

   assign fsm_state_o = state_q;

   // ---------------- shift-add datapath ----------------
   // Only the low B bits of the product are kept, so the multiplicand may
   // shift out of range without affecting the result.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (mul_load) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (mul_step) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   // ---------------- EX/MEM boundary ----------------
   // A bubble clears the control bits and leaves the data fields unchanged.
   always_comb begin
      alu_result_d = alu_result_q;
      zero_d       = zero_q;
      r_data2_d    = r_data2_q;
      write_reg_d  = write_reg_q;
      pc_branch_d  = pc_branch_q;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      branch_d     = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      if (capture) begin
         alu_result_d = alu_res;
         zero_d       = (alu_res == '0);
         r_data2_d    = r_data2_in;
         write_reg_d  = ex_RegDst_in ? inst_15_11_in : inst_20_16_in;
         pc_branch_d  = br_sum[W-1:0];
         reg_write_d  = wb_RegWrite_in;
         mem_to_reg_d = wb_MemtoReg_in;
         branch_d     = m_Branch_in;
         mem_read_d   = m_MemRead_in;
         mem_write_d  = m_MemWrite_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_q <= '0;
         zero_q       <= 1'b0;
         r_data2_q    <= '0;
         write_reg_q  <= '0;
         pc_branch_q  <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         branch_q     <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         zero_q       <= zero_d;
         r_data2_q    <= r_data2_d;
         write_reg_q  <= write_reg_d;
         pc_branch_q  <= pc_branch_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         branch_q     <= branch_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign alu_result_out  = alu_result_q;
   assign zero_out        = zero_q;
   assign r_data2_out     = r_data2_q;
   assign write_reg_out   = write_reg_q;
   assign pc_branch_out   = pc_branch_q;
   assign wb_RegWrite_out = reg_write_q;
   assign wb_MemtoReg_out = mem_to_reg_q;
   assign m_Branch_out    = branch_q;
   assign m_MemRead_out   = mem_read_q;
   assign m_MemWrite_out  = mem_write_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_unit
//
// Directed bench for ex_stage_unit. A reference model predicts the EX/MEM
// outputs from the instruction semantics (ALU table, product a*b, stall
// window length) and a compare process checks every output on each falling
// edge. Hand-computed literals pin the model on the headline cases.
// ---------------------------------------------------------------------------
module tb_ex_stage_unit;

   localparam int B = 32;
   localparam int W = 5;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [W-1:0] pc_next_in     = '0;
   logic [B-1:0] r_data1_in     = '0;
   logic [B-1:0] r_data2_in     = '0;
   logic [B-1:0] sign_ext_in    = '0;
   logic [W-1:0] inst_20_16_in  = '0;
   logic [W-1:0] inst_15_11_in  = '0;
   logic         wb_RegWrite_in = 1'b0;
   logic         wb_MemtoReg_in = 1'b0;
   logic         m_Branch_in    = 1'b0;
   logic         m_MemRead_in   = 1'b0;
   logic         m_MemWrite_in  = 1'b0;
   logic         ex_RegDst_in   = 1'b0;
   logic         ex_ALUOp_in    = 1'b0;
   logic         ex_ALUSrc_in   = 1'b0;
   logic         ex_flush       = 1'b0;

   logic         ex_stall;
   logic [W-1:0] pc_branch_out;
   logic [B-1:0] alu_result_out;
   logic         zero_out;
   logic [B-1:0] r_data2_out;
   logic [W-1:0] write_reg_out;
   logic         wb_RegWrite_out, wb_MemtoReg_out;
   logic         m_Branch_out, m_MemRead_out, m_MemWrite_out;
   logic [1:0]   fsm_state_o;

   ex_stage_unit #(.B(B), .W(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_next_in      (pc_next_in),
      .r_data1_in      (r_data1_in),
      .r_data2_in      (r_data2_in),
      .sign_ext_in     (sign_ext_in),
      .inst_20_16_in   (inst_20_16_in),
      .inst_15_11_in   (inst_15_11_in),
      .wb_RegWrite_in  (wb_RegWrite_in),
      .wb_MemtoReg_in  (wb_MemtoReg_in),
      .m_Branch_in     (m_Branch_in),
      .m_MemRead_in    (m_MemRead_in),
      .m_MemWrite_in   (m_MemWrite_in),
      .ex_RegDst_in    (ex_RegDst_in),
      .ex_ALUOp_in     (ex_ALUOp_in),
      .ex_ALUSrc_in    (ex_ALUSrc_in),
      .ex_flush        (ex_flush),
      .ex_stall        (ex_stall),
      .pc_branch_out   (pc_branch_out),
      .alu_result_out  (alu_result_out),
      .zero_out        (zero_out),
      .r_data2_out     (r_data2_out),
      .write_reg_out   (write_reg_out),
      .wb_RegWrite_out (wb_RegWrite_out),
      .wb_MemtoReg_out (wb_MemtoReg_out),
      .m_Branch_out    (m_Branch_out),
      .m_MemRead_out   (m_MemRead_out),
      .m_MemWrite_out  (m_MemWrite_out),
      .fsm_state_o     (fsm_state_o)
   );

   // ---------------- scoreboard counters ----------------
   int errors = 0;
   int checks = 0;
   logic cmp_en = 1'b0;

   task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [B-1:0] ref_alu(input logic [B-1:0] a, input logic [B-1:0] b,
                                            input logic br, input logic op, input logic [5:0] f);
      if (br)  return a - b;
      if (!op) return a + b;
      case (f)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h27:   return ~(a | b);
         6'h2A:   return ($signed(a) < $signed(b)) ? B'(1) : B'(0);
         default: return '0;
      endcase
   endfunction

   function automatic logic is_mul_in();
      return !m_Branch_in && ex_ALUOp_in && (sign_ext_in[5:0] == 6'h18);
   endfunction

   function automatic logic [B-1:0] op_b_in();
      return ex_ALUSrc_in ? sign_ext_in : r_data2_in;
   endfunction

   // m_phase: 0 = no multiply in flight; k = k edges since the MUL was
   // accepted. Edges 1..B+1 are bubbles, edge B+2 delivers the product.
   int           m_phase = 0;
   logic [B-1:0] m_prod  = '0;
   logic [B-1:0] m_alu   = '0;
   logic         m_zero  = 1'b0;
   logic [B-1:0] m_r2    = '0;
   logic [W-1:0] m_wreg  = '0;
   logic [W-1:0] m_pcb   = '0;
   logic [4:0]   m_ctrl  = '0;  // {RegWrite, MemtoReg, Branch, MemRead, MemWrite}

   function automatic logic [B-1:0] model_result();
      if (m_phase == B + 1) return m_prod;
      return ref_alu(r_data1_in, op_b_in(), m_Branch_in, ex_ALUOp_in, sign_ext_in[5:0]);
   endfunction

   function automatic logic [W-1:0] model_target();
      logic [B-1:0] t;
      t = {{(B-W){1'b0}}, pc_next_in} + (sign_ext_in << 2);
      return t[W-1:0];
   endfunction

   function automatic logic exp_stall();
      return rst_n && !ex_flush && ((m_phase >= 1 && m_phase <= B) || (m_phase == 0 && is_mul_in()));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_alu   <= '0;
         m_zero  <= 1'b0;
         m_r2    <= '0;
         m_wreg  <= '0;
         m_pcb   <= '0;
         m_ctrl  <= '0;
      end else if (ex_flush || (m_phase >= 1 && m_phase <= B) || (m_phase == 0 && is_mul_in())) begin
         m_ctrl  <= '0;
         m_phase <= ex_flush ? 0 : m_phase + 1;
         if (!ex_flush && m_phase == 0) m_prod <= r_data1_in * op_b_in();
      end else begin
         m_alu   <= model_result();
         m_zero  <= (model_result() == '0);
         m_r2    <= r_data2_in;
         m_wreg  <= ex_RegDst_in ? inst_15_11_in : inst_20_16_in;
         m_pcb   <= model_target();
         m_ctrl  <= {wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in, m_MemWrite_in};
         m_phase <= 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("alu_result", alu_result_out, m_alu);
         check("zero", B'(zero_out), B'(m_zero));
         check("r_data2", r_data2_out, m_r2);
         check("write_reg", B'(write_reg_out), B'(m_wreg));
         check("pc_branch", B'(pc_branch_out), B'(m_pcb));
         check("ctrl", B'({wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out}),
               B'(m_ctrl));
         check("ex_stall", B'(ex_stall), B'(exp_stall()));
      end
   end

   // Watches for a product that must never appear after the reset abort.
   logic watch_abort = 1'b0;
   logic saw_abort   = 1'b0;
   always @(negedge clk) begin
      if (watch_abort && alu_result_out == 32'd143) saw_abort = 1'b1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   // ex_c = {RegDst, ALUOp, ALUSrc}; wm_c = {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
   task automatic drive(input logic [B-1:0] r1, input logic [B-1:0] r2, input logic [B-1:0] imm,
                        input logic [W-1:0] pcn, input logic [W-1:0] rt, input logic [W-1:0] rd,
                        input logic [2:0] ex_c, input logic [4:0] wm_c);
      r_data1_in     = r1;
      r_data2_in     = r2;
      sign_ext_in    = imm;
      pc_next_in     = pcn;
      inst_20_16_in  = rt;
      inst_15_11_in  = rd;
      ex_RegDst_in   = ex_c[2];
      ex_ALUOp_in    = ex_c[1];
      ex_ALUSrc_in   = ex_c[0];
      wb_RegWrite_in = wm_c[4];
      wb_MemtoReg_in = wm_c[3];
      m_Branch_in    = wm_c[2];
      m_MemRead_in   = wm_c[1];
      m_MemWrite_in  = wm_c[0];
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   logic [B-1:0] tv_a [5];
   logic [B-1:0] tv_b [5];
   logic [5:0]   tv_f [5];
   logic [B-1:0] tv_r [5];
   int           n;

   initial begin
      tv_a = '{32'd5, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'd9};
      tv_b = '{32'd7, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'd9};
      tv_f = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h3F};
      tv_r = '{32'hFFFFFFFE, 32'h0000F000, 32'h0000FFF0, 32'hFFFF000F, 32'h0};

      // reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst alu_result", alu_result_out, 32'h0);
      check("rst write_reg", B'(write_reg_out), 32'h0);
      check("rst RegWrite", B'(wb_RegWrite_out), 32'h0);
      check("rst ex_stall", B'(ex_stall), 32'h0);
      check("rst fsm", B'(fsm_state_o), 32'h0);
      #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // ADD 5+7 into rd=3
      drive(32'd5, 32'd7, 32'h20, 5'd0, 5'd2, 5'd3, 3'b110, 5'b10000);
      tick();
      check("add result", alu_result_out, 32'd12);
      check("add zero", B'(zero_out), 32'h0);
      check("add write_reg", B'(write_reg_out), 32'd3);
      check("add RegWrite", B'(wb_RegWrite_out), 32'h1);

      // SLT signed, both operand orders
      drive(32'hFFFFFFFF, 32'd1, 32'h2A, 5'd0, 5'd2, 5'd4, 3'b110, 5'b10000);
      tick();
      check("slt -1<1", alu_result_out, 32'd1);
      drive(32'd1, 32'hFFFFFFFF, 32'h2A, 5'd0, 5'd2, 5'd4, 3'b110, 5'b10000);
      tick();
      check("slt 1<-1", alu_result_out, 32'd0);
      check("slt zero", B'(zero_out), 32'h1);

      // BEQ r1=r2=9, pc_next=4, offset 1
      drive(32'd9, 32'd9, 32'd1, 5'd4, 5'd6, 5'd7, 3'b000, 5'b00100);
      tick();
      check("beq zero", B'(zero_out), 32'h1);
      check("beq target", B'(pc_branch_out), 32'd8);
      check("beq write_reg", B'(write_reg_out), 32'd6);
      check("beq Branch", B'(m_Branch_out), 32'h1);

      // LW 100 + (-4)
      drive(32'd100, 32'd0, 32'hFFFFFFFC, 5'd0, 5'd5, 5'd0, 3'b001, 5'b11010);
      tick();
      check("lw result", alu_result_out, 32'd96);
      check("lw MemRead", B'(m_MemRead_out), 32'h1);
      check("lw MemtoReg", B'(wb_MemtoReg_out), 32'h1);
      check("lw target", B'(pc_branch_out), 32'd16);

      // R-type table: SUB, AND, OR, NOR, unknown funct
      for (int i = 0; i < 5; i++) begin
         drive(tv_a[i], tv_b[i], {26'h0, tv_f[i]}, 5'd1, 5'd2, 5'd10, 3'b110, 5'b10000);
         tick();
         check("rtype table", alu_result_out, tv_r[i]);
      end

      // ALUOp=0 with a MUL-like funct is a plain ADD
      drive(32'd3, 32'd4, 32'h18, 5'd0, 5'd2, 5'd11, 3'b100, 5'b10000);
      #1;
      check("aluop0 no stall", B'(ex_stall), 32'h0);
      tick();
      check("aluop0 add", alu_result_out, 32'd7);

      // MUL 7 * -3, then an ADD straight behind it
      drive(32'd7, 32'hFFFFFFFD, 32'h18, 5'd0, 5'd8, 5'd9, 3'b110, 5'b10000);
      #1;
      n = 0;
      while (ex_stall && n < 100) begin
         n++;
         tick();
      end
      check("mul stall cycles", B'(n), 32'd33);
      check("mul bubble RegWrite", B'(wb_RegWrite_out), 32'h0);
      tick();
      check("mul result", alu_result_out, 32'hFFFFFFEB);
      check("mul RegWrite", B'(wb_RegWrite_out), 32'h1);
      check("mul write_reg", B'(write_reg_out), 32'd9);
      drive(32'd1, 32'd2, 32'h20, 5'd0, 5'd2, 5'd12, 3'b110, 5'b10000);
      tick();
      check("add after mul", alu_result_out, 32'd3);

      // flush while BUSY at cnt=10
      drive(32'd3, 32'd5, 32'h18, 5'd0, 5'd8, 5'd13, 3'b110, 5'b10000);
      tick();
      repeat (10) tick();
      check("flush pre fsm busy", B'(fsm_state_o), 32'd1);
      ex_flush = 1'b1;
      #1;
      check("flush stall low", B'(ex_stall), 32'h0);
      tick();
      check("flush fsm idle", B'(fsm_state_o), 32'd0);
      check("flush bubble", B'(wb_RegWrite_out), 32'h0);
      ex_flush = 1'b0;
      drive(32'd6, 32'd1, 32'h20, 5'd0, 5'd2, 5'd14, 3'b110, 5'b10000);
      tick();
      check("add after flush", alu_result_out, 32'd7);

      // async reset at cnt=5 aborts the multiply
      drive(32'd11, 32'd13, 32'h18, 5'd3, 5'd8, 5'd15, 3'b110, 5'b10000);
      tick();
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("abort alu_result", alu_result_out, 32'h0);
      check("abort write_reg", B'(write_reg_out), 32'h0);
      check("abort RegWrite", B'(wb_RegWrite_out), 32'h0);
      check("abort stall", B'(ex_stall), 32'h0);
      check("abort fsm", B'(fsm_state_o), 32'h0);
      drive(32'd0, 32'd0, 32'h20, 5'd0, 5'd0, 5'd0, 3'b110, 5'b00000);
      watch_abort = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      watch_abort = 1'b0;
      check("abort no product", B'(saw_abort), 32'h0);

      tick();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
